// File: rtl/ps2_frame_if.sv
// PS/2 pin and scan-code bundle between the keyboard pins and the frame receiver.
// The slave modport is the receiver's view; the master modport is the pin driver / consumer view.
interface ps2_frame_if;
    logic       kb_clk;
    logic       kb_data;
    logic [7:0] sc;
    logic       sc_valid;
    logic       sc_release;
    logic       frame_err;

    modport master (
        output kb_clk, kb_data,
        input  sc, sc_valid, sc_release, frame_err
    );

    modport slave (
        input  kb_clk, kb_data,
        output sc, sc_valid, sc_release, frame_err
    );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard front end: synchronizes kb_clk/kb_data, deframes 11-bit frames, tracks the 0xF0 break prefix.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_frame_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_hist_q, clk_hist_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       brk_pend_q, brk_pend_d;
    logic [7:0] sc_q, sc_d;
    logic       sc_release_q, sc_release_d;
    logic       sc_valid_q, sc_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fe;
    logic d;
    logic parity_ok;

    // Data goes through the same depth as the clock so the sampled bit lines up with fe.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.kb_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.kb_data};
        clk_hist_d  = clk_sync_q[SYNC_STAGES-1];
    end

    assign fe = clk_hist_q & ~clk_sync_q[SYNC_STAGES-1];
    assign d  = data_sync_q[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        brk_pend_d   = brk_pend_q;
        sc_d         = sc_q;
        sc_release_d = sc_release_q;
        sc_valid_d   = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE || fe) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        // Expiry takes priority over a coincident fe, which is then consumed.
        if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
        end else if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!d) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                        brk_pend_d  = 1'b0;
                    end
                end
                DATA: begin
                    shift_d   = {d, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = d;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (d && parity_ok) begin
                        if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            sc_d         = shift_q;
                            sc_release_d = brk_pend_q;
                            sc_valid_d   = 1'b1;
                            brk_pend_d   = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        brk_pend_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sync and history flops reset high so reset release can never look like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_hist_q   <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            brk_pend_q   <= 1'b0;
            sc_q         <= 8'h00;
            sc_release_q <= 1'b0;
            sc_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            tmo_q        <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_hist_q   <= clk_hist_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            brk_pend_q   <= brk_pend_d;
            sc_q         <= sc_d;
            sc_release_q <= sc_release_d;
            sc_valid_q   <= sc_valid_d;
            frame_err_q  <= frame_err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.sc         = sc_q;
    assign bus.sc_release = sc_release_q;
    assign bus.sc_valid   = sc_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: table of whole frames plus hand-written timeout, bad-start and mid-frame reset sequences.
// Expected strobes are queued when a frame is driven and matched against strobes the monitor observes.
module tb_ps2_frame_receiver;
    localparam int TMO = 64;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    ps2_frame_if bus();

    ps2_frame_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ev: 0 = no strobe, 1 = sc_valid, 2 = frame_err; sc/rel are the values expected afterwards.
    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         ev;
        logic [7:0] sc;
        logic       rel;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] sc;
        logic       rel;
    } evt_t;

    vec_t tbl [12];
    evt_t exp_q [$];
    evt_t seen_q [$];
    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin : monitor
        evt_t e;
        if (!rst && (bus.sc_valid || bus.frame_err)) begin
            e.is_err = bus.frame_err;
            e.sc     = bus.sc;
            e.rel    = bus.sc_release;
            seen_q.push_back(e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.kb_data = bits[i];
            tick(4);
            bus.kb_clk = 1'b0;
            tick(8);
            bus.kb_clk = 1'b1;
            tick(4);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        send_bits({stop, par, data, 1'b0}, 11);
    endtask

    task automatic expect_evt(input logic is_err, input logic [7:0] sc, input logic rel);
        evt_t e;
        e.is_err = is_err;
        e.sc     = sc;
        e.rel    = rel;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h", name, actual, required);
        end
    endtask

    task automatic drain(input string name);
        evt_t s;
        evt_t x;
        tick(12);
        @(negedge clk);
        while (seen_q.size() > 0) begin
            s = seen_q.pop_front();
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL %s: unexpected strobe err=%0b sc=%02h rel=%0b, expected none",
                         name, s.is_err, s.sc, s.rel);
            end else begin
                x = exp_q.pop_front();
                if (s.is_err !== x.is_err || (!x.is_err && (s.sc !== x.sc || s.rel !== x.rel))) begin
                    miscompares++;
                    $display("FAIL %s: got err=%0b sc=%02h rel=%0b, expected err=%0b sc=%02h rel=%0b",
                             name, s.is_err, s.sc, s.rel, x.is_err, x.sc, x.rel);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected strobe(s) never seen, expected 0 outstanding", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_sc"},         bus.sc, 8'h00);
        check({name, "_sc_valid"},   {7'd0, bus.sc_valid}, 8'h00);
        check({name, "_sc_release"}, {7'd0, bus.sc_release}, 8'h00);
        check({name, "_frame_err"},  {7'd0, bus.frame_err}, 8'h00);
    endtask

    initial begin
        logic [7:0] held_sc;

        tbl[0]  = '{8'h1C, 1'b1, 1'b1, (PAR_EN ? 2 : 1), (PAR_EN ? 8'h00 : 8'h1C), 1'b0};
        tbl[1]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0};
        tbl[2]  = '{8'hF0, 1'b1, 1'b1, 0, 8'h1C, 1'b0};
        tbl[3]  = '{8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b1};
        tbl[4]  = '{8'h23, 1'b0, 1'b0, 2, 8'h1C, 1'b1};
        tbl[5]  = '{8'h23, 1'b0, 1'b1, 1, 8'h23, 1'b0};
        tbl[6]  = '{8'h1B, 1'b1, 1'b1, 1, 8'h1B, 1'b0};
        tbl[7]  = '{8'hE0, 1'b0, 1'b1, 1, 8'hE0, 1'b0};
        tbl[8]  = '{8'hF0, 1'b1, 1'b1, 0, 8'hE0, 1'b0};
        tbl[9]  = '{8'h55, 1'b1, 1'b0, 2, 8'hE0, 1'b0};
        tbl[10] = '{8'h32, 1'b0, 1'b1, 1, 8'h32, 1'b0};
        tbl[11] = '{8'h1B, 1'b0, 1'b1, (PAR_EN ? 2 : 1), (PAR_EN ? 8'h32 : 8'h1B), 1'b0};

        bus.kb_clk  = 1'b1;
        bus.kb_data = 1'b1;
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 12; i++) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            if (tbl[i].ev == 1) expect_evt(1'b0, tbl[i].sc, tbl[i].rel);
            if (tbl[i].ev == 2) expect_evt(1'b1, 8'h00, 1'b0);
            drain($sformatf("vec%0d_%02h", i, tbl[i].data));
            check($sformatf("vec%0d_sc", i), bus.sc, tbl[i].sc);
            check($sformatf("vec%0d_rel", i), {7'd0, bus.sc_release}, {7'd0, tbl[i].rel});
            $display("vec %0d: data=%02h par=%0b stop=%0b -> sc=%02h rel=%0b", i,
                     tbl[i].data, tbl[i].par, tbl[i].stop, bus.sc, bus.sc_release);
        end
        held_sc = tbl[11].sc;

        // A falling edge with data high in IDLE is a bad start bit.
        send_bits(11'b1, 1);
        expect_evt(1'b1, 8'h00, 1'b0);
        drain("bad_start");
        check("bad_start_sc", bus.sc, held_sc);
        $display("bad start bit: sc=%02h", bus.sc);

        // Stall after start + 4 data bits; the error must not come early.
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 5);
        tick(30);
        vectors++;
        if (seen_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_early: got %0d strobe(s), expected 0", seen_q.size());
        end
        expect_evt(1'b1, 8'h00, 1'b0);
        tick(TMO);
        drain("timeout");
        check("timeout_sc", bus.sc, held_sc);
        send_frame(8'h32, 1'b0, 1'b1);
        expect_evt(1'b0, 8'h32, 1'b0);
        drain("after_timeout");
        check("after_timeout_sc", bus.sc, 8'h32);
        $display("timeout recovery: sc=%02h", bus.sc);

        // Pending break, then a partial frame cut by reset: nothing from either may leak through.
        send_frame(8'hF0, 1'b1, 1'b1);
        drain("pre_reset_break");
        send_bits({1'b1, 1'b0, 8'h77, 1'b0}, 5);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        tick(3);
        rst = 1'b0;
        tick(10);
        drain("reset_release");
        send_frame(8'h45, 1'b0, 1'b1);
        expect_evt(1'b0, 8'h45, 1'b0);
        drain("after_reset");
        check("after_reset_sc", bus.sc, 8'h45);
        check("after_reset_rel", {7'd0, bus.sc_release}, 8'h00);
        $display("post-reset frame: sc=%02h rel=%0b", bus.sc, bus.sc_release);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
